// File: rtl/inst_rom_pkg.sv
// +--------------------------------------------------------------------+
// | inst_rom_pkg : shared defines, FSM encodings and byte-lane helper  |
// | Revision     : 1.0                                                 |
// +--------------------------------------------------------------------+
`default_nettype none

`ifndef INST_ROM_DEFINES
`define INST_ROM_DEFINES
`define RstEnable   1'b1
`define RstDisable  1'b0
`define ChipEnable  1'b1
`define ChipDisable 1'b0
`define InstAddrBus 31:0
`define InstBus     31:0
`define ZeroWord    32'h0000_0000
`define StateLoad   2'd0
`define StateRun    2'd1
`define StateErr    2'd2
`endif

package inst_rom_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = `StateLoad,
    ST_RUN  = `StateRun,
    ST_ERR  = `StateErr
  } state_e;

  localparam logic [1:0] c_last_byte_idx = 2'd3;

  // Big-endian placement: byte index 0 lands in bits 31:24.
  function automatic logic [31:0] place_byte(input logic [7:0] b, input logic [1:0] idx);
    return {b, 24'h0} >> {idx, 3'b000};
  endfunction

endpackage

`default_nettype wire

// File: rtl/inst_rom_if.sv
// +--------------------------------------------------------------------+
// | inst_rom_if : instruction fetch port plus boot-loader byte stream  |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
`default_nettype none

interface inst_rom_if;
  import inst_rom_pkg::*;

  logic                ce;
  logic [`InstAddrBus] addr;
  logic [`InstBus]     inst;
  logic                ld_valid;
  logic [7:0]          ld_byte;
  logic                ld_last;
  logic                ld_ready;

  modport master (
    output ce, addr, ld_valid, ld_byte, ld_last,
    input  inst, ld_ready
  );

  modport slave (
    input  ce, addr, ld_valid, ld_byte, ld_last,
    output inst, ld_ready
  );
endinterface

`default_nettype wire

// File: rtl/inst_mem_array.sv
// +--------------------------------------------------------------------+
// | inst_mem_array : 1W/1R word memory, async read, no reset           |
// | Revision       : 1.0                                               |
// +--------------------------------------------------------------------+
`default_nettype none

module inst_mem_array #(
  parameter int ADDR_W = 10
) (
  input  wire logic              clk,
  input  wire logic              we,
  input  wire logic [ADDR_W-1:0] waddr,
  input  wire logic [31:0]       wdata,
  input  wire logic [ADDR_W-1:0] raddr,
  output logic      [31:0]       rdata
);

  logic [31:0] r_mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/inst_rom.sv
// +--------------------------------------------------------------------+
// | inst_rom : boot-loaded instruction memory with zero-latency fetch  |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
`default_nettype none

module inst_rom
  import inst_rom_pkg::*;
#(
  parameter int INST_MEM_NUM_LOG2 = 10
) (
  input  wire logic                       clk,
  input  wire logic                       rst,
  inst_rom_if.slave                       bus,
  output logic                            boot_done,
  output logic                            ld_err,
  output logic [INST_MEM_NUM_LOG2:0]      word_cnt
);

  localparam int                         c_aw   = INST_MEM_NUM_LOG2;
  localparam logic [INST_MEM_NUM_LOG2:0] c_full = {1'b1, {INST_MEM_NUM_LOG2{1'b0}}};

  state_e          r_state, w_state_nxt;
  logic [c_aw:0]   r_word_cnt, w_word_cnt_nxt;
  logic [1:0]      r_byte_idx, w_byte_idx_nxt;
  logic [31:0]     r_asm, w_asm_nxt;
  logic [31:0]     w_word;
  logic            w_we;
  logic [c_aw-1:0] w_rd_idx;
  logic [31:0]     w_rdata;
  logic            w_addr_in_range;
  logic            w_unused_addr_lsb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst == `RstEnable) begin
      r_state    <= ST_LOAD;
      r_word_cnt <= '0;
      r_byte_idx <= '0;
      r_asm      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_word_cnt <= w_word_cnt_nxt;
      r_byte_idx <= w_byte_idx_nxt;
      r_asm      <= w_asm_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_word_cnt_nxt = r_word_cnt;
    w_byte_idx_nxt = r_byte_idx;
    w_asm_nxt      = r_asm;
    w_we           = 1'b0;
    // Lower byte lanes of r_asm are still zero, so a short final word is padded for free.
    w_word         = r_asm | place_byte(bus.ld_byte, r_byte_idx);
    case (r_state)
      ST_LOAD: begin
        if (bus.ld_valid) begin
          if (r_word_cnt == c_full) begin
            w_state_nxt = ST_ERR;
          end else if (bus.ld_last || (r_byte_idx == c_last_byte_idx)) begin
            w_we           = 1'b1;
            w_word_cnt_nxt = r_word_cnt + (c_aw+1)'(1);
            w_byte_idx_nxt = '0;
            w_asm_nxt      = '0;
            if (bus.ld_last) begin
              w_state_nxt = ST_RUN;
            end
          end else begin
            w_byte_idx_nxt = r_byte_idx + 2'd1;
            w_asm_nxt      = w_word;
          end
        end
      end
      default: ;
    endcase
  end

  inst_mem_array #(
    .ADDR_W (c_aw)
  ) u_mem (
    .clk   (clk),
    .we    (w_we),
    .waddr (r_word_cnt[c_aw-1:0]),
    .wdata (w_word),
    .raddr (w_rd_idx),
    .rdata (w_rdata)
  );

  assign w_rd_idx          = bus.addr[c_aw+1:2];
  assign w_unused_addr_lsb = ^bus.addr[1:0];
  assign w_addr_in_range   = ~|bus.addr[31:c_aw+2] && ({1'b0, w_rd_idx} < r_word_cnt);

  assign bus.inst = ((rst != `RstEnable) && (r_state == ST_RUN) &&
                     (bus.ce == `ChipEnable) && w_addr_in_range) ? w_rdata : `ZeroWord;

  assign bus.ld_ready = (r_state == ST_LOAD);
  assign boot_done    = (r_state == ST_RUN);
  assign ld_err       = (r_state == ST_ERR);
  assign word_cnt     = r_word_cnt;

endmodule

`default_nettype wire

// File: tb/tb_inst_rom.sv
// +--------------------------------------------------------------------+
// | tb_inst_rom : directed bench for inst_rom (default and depth 4)    |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_inst_rom;

  logic        clk;
  logic        rst;
  logic        boot_done_a, ld_err_a;
  logic [10:0] word_cnt_a;
  logic        boot_done_b, ld_err_b;
  logic [2:0]  word_cnt_b;
  int          n_checks;
  int          n_errors;

  inst_rom_if ifa ();
  inst_rom_if ifb ();

  inst_rom dut_a (
    .clk       (clk),
    .rst       (rst),
    .bus       (ifa.slave),
    .boot_done (boot_done_a),
    .ld_err    (ld_err_a),
    .word_cnt  (word_cnt_a)
  );

  inst_rom #(.INST_MEM_NUM_LOG2(2)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .bus       (ifb.slave),
    .boot_done (boot_done_b),
    .ld_err    (ld_err_b),
    .word_cnt  (word_cnt_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // One byte offered for one cycle on the default-depth instance, then `gap` idle cycles.
  task automatic send_a(input logic [7:0] b, input logic last, input int gap);
    @(negedge clk);
    ifa.ld_valid = 1'b1;
    ifa.ld_byte  = b;
    ifa.ld_last  = last;
    @(negedge clk);
    ifa.ld_valid = 1'b0;
    ifa.ld_last  = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_b(input logic [7:0] b);
    @(negedge clk);
    ifb.ld_valid = 1'b1;
    ifb.ld_byte  = b;
    ifb.ld_last  = 1'b0;
    @(negedge clk);
    ifb.ld_valid = 1'b0;
  endtask

  task automatic fetch_a(input string tag, input logic ce, input logic [31:0] a, input logic [31:0] exp);
    ifa.ce   = ce;
    ifa.addr = a;
    #1;
    chk(tag, ifa.inst, exp);
  endtask

  task automatic pulse_reset;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] img1 [8];
    n_checks = 0;
    n_errors = 0;
    img1 = '{8'h3C, 8'h01, 8'h12, 8'h34, 8'h34, 8'h21, 8'h56, 8'h78};
    rst = 1'b1;
    ifa.ce = 1'b1; ifa.addr = '0; ifa.ld_valid = 1'b0; ifa.ld_byte = '0; ifa.ld_last = 1'b0;
    ifb.ce = 1'b1; ifb.addr = '0; ifb.ld_valid = 1'b0; ifb.ld_byte = '0; ifb.ld_last = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_boot_done", 32'(boot_done_a), 32'd0);
    chk("rst_ld_err",    32'(ld_err_a),    32'd0);
    chk("rst_word_cnt",  32'(word_cnt_a),  32'd0);
    chk("rst_inst",      ifa.inst,         32'h0);
    rst = 1'b0;
    #1;
    chk("rst_ld_ready",  32'(ifa.ld_ready), 32'd1);

    // Two-word image with idle gaps between some bytes.
    for (int i = 0; i < 8; i++) begin
      send_a(img1[i], i == 7, (i % 3 == 1) ? 2 : 0);
    end
    chk("img1_boot_done", 32'(boot_done_a),   32'd1);
    chk("img1_word_cnt",  32'(word_cnt_a),    32'd2);
    chk("img1_ld_ready",  32'(ifa.ld_ready),  32'd0);
    fetch_a("img1_addr0",   1'b1, 32'h0000_0000, 32'h3C01_1234);
    fetch_a("img1_addr4",   1'b1, 32'h0000_0004, 32'h3421_5678);
    fetch_a("img1_addr2",   1'b1, 32'h0000_0002, 32'h3C01_1234);
    fetch_a("img1_addr8",   1'b1, 32'h0000_0008, 32'h0);
    fetch_a("img1_ce_off",  1'b0, 32'h0000_0000, 32'h0);
    fetch_a("img1_hi_addr", 1'b1, 32'h0000_1000, 32'h0);

    // Loader activity while running must not disturb memory or the counter.
    repeat (3) send_a(8'hFF, 1'b1, 0);
    chk("run_word_cnt", 32'(word_cnt_a), 32'd2);
    fetch_a("run_addr0", 1'b1, 32'h0000_0000, 32'h3C01_1234);
    fetch_a("run_addr4", 1'b1, 32'h0000_0004, 32'h3421_5678);
    fetch_a("run_addr8", 1'b1, 32'h0000_0008, 32'h0);

    // Asynchronous reset mid-load, then reload a single word.
    pulse_reset();
    for (int i = 0; i < 6; i++) begin
      send_a(8'(i + 1), 1'b0, 0);
    end
    chk("mid_word_cnt", 32'(word_cnt_a), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_word_cnt", 32'(word_cnt_a),   32'd0);
    chk("async_inst",     ifa.inst,          32'h0);
    @(negedge clk);
    rst = 1'b0;
    send_a(8'h11, 1'b0, 0);
    send_a(8'h22, 1'b0, 1);
    send_a(8'h33, 1'b0, 0);
    send_a(8'h44, 1'b1, 0);
    chk("reload_word_cnt",  32'(word_cnt_a),  32'd1);
    chk("reload_boot_done", 32'(boot_done_a), 32'd1);
    fetch_a("reload_addr0", 1'b1, 32'h0000_0000, 32'h1122_3344);
    fetch_a("reload_addr4", 1'b1, 32'h0000_0004, 32'h0);

    // Five-byte image: last word zero-padded.
    pulse_reset();
    send_a(8'hAA, 1'b0, 0);
    send_a(8'hBB, 1'b0, 0);
    send_a(8'hCC, 1'b0, 0);
    send_a(8'hDD, 1'b0, 0);
    send_a(8'hEE, 1'b1, 0);
    chk("pad_word_cnt", 32'(word_cnt_a), 32'd2);
    fetch_a("pad_addr0", 1'b1, 32'h0000_0000, 32'hAABB_CCDD);
    fetch_a("pad_addr4", 1'b1, 32'h0000_0004, 32'hEE00_0000);
    fetch_a("pad_addr8", 1'b1, 32'h0000_0008, 32'h0);

    // Depth-4 instance: 17th byte overflows.
    pulse_reset();
    for (int i = 0; i < 16; i++) begin
      send_b(8'(8'h10 + i));
    end
    chk("ovf_word_cnt_full", 32'(word_cnt_b), 32'd4);
    chk("ovf_err_before",    32'(ld_err_b),   32'd0);
    send_b(8'h20);
    chk("ovf_ld_err",    32'(ld_err_b),       32'd1);
    chk("ovf_ld_ready",  32'(ifb.ld_ready),   32'd0);
    chk("ovf_boot_done", 32'(boot_done_b),    32'd0);
    chk("ovf_inst",      ifb.inst,            32'h0);
    send_b(8'h21);
    chk("ovf_word_cnt",  32'(word_cnt_b),     32'd4);
    chk("ovf_err_hold",  32'(ld_err_b),       32'd1);
    chk("ovf_mem0", dut_b.u_mem.r_mem[0], 32'h1011_1213);
    chk("ovf_mem1", dut_b.u_mem.r_mem[1], 32'h1415_1617);
    chk("ovf_mem2", dut_b.u_mem.r_mem[2], 32'h1819_1A1B);
    chk("ovf_mem3", dut_b.u_mem.r_mem[3], 32'h1C1D_1E1F);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
